rotating_word_buffer: RTL and testbench



---
 rtl/rwb_pkg.sv | 25 ++
 rtl/rwb_counter.sv | 58 +++++
 rtl/rotating_word_buffer.sv | 89 ++++++++
 tb/tb_rotating_word_buffer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/rwb_pkg.sv
// Shared sizing helpers and insert-mode encoding for the rotating word buffer.
package rwb_pkg;

    // Counter width for a modulus of n: clog2, but never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    typedef enum logic [1:0] {
        INS_RECIRC = 2'd0,
        INS_WRITE  = 2'd1,
        INS_CLEAR  = 2'd2
    } ins_mode_e;

    // Clear outranks write; with neither, the load slot recirculates.
    function automatic ins_mode_e ins_mode(input logic clear, input logic write);
        if (clear) begin
            return INS_CLEAR;
        end else if (write) begin
            return INS_WRITE;
        end
        return INS_RECIRC;
    endfunction

endpackage

// File: rtl/rwb_counter.sv
// Bit position and word index counters; flags the rotating edge and the index wrap.
module rwb_counter
    import rwb_pkg::*;
#(
    parameter int WORD_WIDTH = 8,
    parameter int WORD_COUNT = 24,
    localparam int BIT_W = clog2_min1(WORD_WIDTH),
    localparam int IDX_W = clog2_min1(WORD_COUNT)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [BIT_W-1:0] bit_cnt,
    output logic [IDX_W-1:0] word_idx,
    output logic             rotate,
    output logic             wrap
);

    logic [BIT_W-1:0] bit_cnt_q;
    logic [BIT_W-1:0] bit_cnt_d;
    logic [IDX_W-1:0] word_idx_q;
    logic [IDX_W-1:0] word_idx_d;
    logic             bit_last;
    logic             idx_last;

    // Explicit compares so non-power-of-two moduli wrap correctly.
    assign bit_last = (bit_cnt_q == BIT_W'(WORD_WIDTH - 1));
    assign idx_last = (word_idx_q == IDX_W'(WORD_COUNT - 1));
    assign rotate   = en & bit_last;
    assign wrap     = rotate & idx_last;

    always_comb begin
        bit_cnt_d  = bit_cnt_q;
        word_idx_d = word_idx_q;
        if (en) begin
            if (bit_last) begin
                bit_cnt_d  = '0;
                word_idx_d = idx_last ? '0 : word_idx_q + 1'b1;
            end else begin
                bit_cnt_d = bit_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt_q  <= '0;
            word_idx_q <= '0;
        end else begin
            bit_cnt_q  <= bit_cnt_d;
            word_idx_q <= word_idx_d;
        end
    end

    assign bit_cnt  = bit_cnt_q;
    assign word_idx = word_idx_q;

endmodule

// File: rtl/rotating_word_buffer.sv
// Circular word memory: bits shift LSB-first into slot 1, and the ring rotates
// one word every WORD_WIDTH enabled clocks so slot 0 walks through the stored words.
module rotating_word_buffer
    import rwb_pkg::*;
#(
    parameter int WORD_WIDTH = 8,
    parameter int WORD_COUNT = 24,
    localparam int BIT_W = clog2_min1(WORD_WIDTH),
    localparam int IDX_W = clog2_min1(WORD_COUNT)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  write,
    input  logic                  clear,
    input  logic                  din,
    output logic [WORD_WIDTH-1:0] dout_word,
    output logic [IDX_W-1:0]      word_idx,
    output logic [BIT_W-1:0]      bit_cnt,
    output logic                  frame_start,
    output logic                  serial_out
);

    logic [WORD_COUNT-1:0][WORD_WIDTH-1:0] slot_q;
    logic [WORD_COUNT-1:0][WORD_WIDTH-1:0] slot_d;
    logic [WORD_WIDTH-1:0]                 load_shift;
    logic                                  frame_start_q;
    logic                                  frame_start_d;
    logic                                  ins_bit;
    logic                                  rotate;
    logic                                  wrap;
    ins_mode_e                             mode;

    rwb_counter #(
        .WORD_WIDTH (WORD_WIDTH),
        .WORD_COUNT (WORD_COUNT)
    ) u_counter (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .bit_cnt  (bit_cnt),
        .word_idx (word_idx),
        .rotate   (rotate),
        .wrap     (wrap)
    );

    always_comb begin
        mode    = ins_mode(clear, write);
        ins_bit = slot_q[1][0];
        case (mode)
            INS_CLEAR: ins_bit = 1'b0;
            INS_WRITE: ins_bit = din;
            default:   ins_bit = slot_q[1][0];
        endcase
    end

    assign load_shift = {ins_bit, slot_q[1][WORD_WIDTH-1:1]};

    // Rotation moves slot k+1 to slot k and old slot 0 to the top; slot 0 is
    // then overwritten by the freshly completed load word. Also covers WORD_COUNT = 2.
    always_comb begin
        slot_d        = slot_q;
        frame_start_d = frame_start_q;
        if (en) begin
            frame_start_d = wrap;
            if (rotate) begin
                slot_d    = {slot_q[0], slot_q[WORD_COUNT-1:1]};
                slot_d[0] = load_shift;
            end else begin
                slot_d[1] = load_shift;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_q        <= '0;
            frame_start_q <= 1'b0;
        end else begin
            slot_q        <= slot_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign dout_word   = slot_q[0];
    assign frame_start = frame_start_q;
    assign serial_out  = slot_q[1][0];

endmodule

// File: tb/tb_rotating_word_buffer.sv
// Directed bench for rotating_word_buffer with WORD_WIDTH=8, WORD_COUNT=4.
module tb_rotating_word_buffer;

    localparam int WW = 8;
    localparam int WC = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          en;
    logic          write;
    logic          clear;
    logic          din;
    logic [WW-1:0] dout_word;
    logic [1:0]    word_idx;
    logic [2:0]    bit_cnt;
    logic          frame_start;
    logic          serial_out;

    int            total = 0;
    int            bad   = 0;
    logic [WW-1:0] exp_q[$];
    logic [WW-1:0] cur;
    logic [WW-1:0] w;

    rotating_word_buffer #(
        .WORD_WIDTH (WW),
        .WORD_COUNT (WC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .write       (write),
        .clear       (clear),
        .din         (din),
        .dout_word   (dout_word),
        .word_idx    (word_idx),
        .bit_cnt     (bit_cnt),
        .frame_start (frame_start),
        .serial_out  (serial_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic e, input logic wr, input logic cl, input logic d);
        en    = e;
        write = wr;
        clear = cl;
        din   = d;
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [WW-1:0] word);
        for (int i = 0; i < WW; i++) begin
            step(1'b1, 1'b1, 1'b0, word[i]);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        en    = 1'b0;
        write = 1'b0;
        clear = 1'b0;
        din   = 1'b0;

        // 1: reset state before any clock edge
        #2;
        check("t1_dout", dout_word, 8'h00);
        check("t1_idx", word_idx, 0);
        check("t1_bitcnt", bit_cnt, 0);
        check("t1_frame", frame_start, 0);
        check("t1_sout", serial_out, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // 2: single word 0xA5
        w = 8'hA5;
        for (int i = 0; i < WW - 1; i++) begin
            step(1'b1, 1'b1, 1'b0, w[i]);
        end
        check("t2_bitcnt7", bit_cnt, 7);
        check("t2_dout_pre", dout_word, 8'h00);
        step(1'b1, 1'b1, 1'b0, w[7]);
        check("t2_dout", dout_word, 8'hA5);
        check("t2_idx", word_idx, 1);
        check("t2_bitcnt", bit_cnt, 0);
        check("t2_frame", frame_start, 0);

        // 3: load four words, then recirculate a full frame
        load_word(8'h11);
        load_word(8'h22);
        load_word(8'h33);
        check("t3_wrap_idx", word_idx, 0);
        check("t3_wrap_frame", frame_start, 1);
        load_word(8'h44);
        check("t3_dout44", dout_word, 8'h44);
        check("t3_idx1", word_idx, 1);
        check("t3_frame_drop", frame_start, 0);
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        exp_q.push_back(8'h33);
        exp_q.push_back(8'h44);
        cur = 8'h44;
        for (int i = 0; i < 4 * WW; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
            if ((i % WW) == WW - 1) begin
                cur = exp_q.pop_front();
            end
            check("t3_dout", dout_word, cur);
            check("t3_bitcnt", bit_cnt, (i + 1) % WW);
            check("t3_frame", frame_start, (i == 2 * WW + WW - 1) ? 1 : 0);
        end
        check("t3_idx_end", word_idx, 1);

        // 4: enable pause mid-word
        w = 8'h5C;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'b0, w[i]);
        end
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'b1, 1'b0, k[0]);
            check("t4_hold_bitcnt", bit_cnt, 3);
            check("t4_hold_dout", dout_word, 8'h44);
            check("t4_hold_idx", word_idx, 1);
        end
        for (int i = 3; i < WW - 1; i++) begin
            step(1'b1, 1'b1, 1'b0, w[i]);
        end
        check("t4_bitcnt7", bit_cnt, 7);
        step(1'b1, 1'b1, 1'b0, w[7]);
        check("t4_dout", dout_word, 8'h5C);
        check("t4_idx", word_idx, 2);
        check("t4_bitcnt", bit_cnt, 0);

        // 5: clear wins over write on a ring of 0xFF
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int k = 0; k < WC; k++) begin
            load_word(8'hFF);
        end
        check("t5_full_idx", word_idx, 0);
        check("t5_full_frame", frame_start, 1);
        check("t5_full_sout", serial_out, 1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("t5_frame_held", frame_start, 1);
        for (int i = 0; i < WW; i++) begin
            step(1'b1, 1'b1, 1'b1, 1'b1);
        end
        check("t5_clear_dout", dout_word, 8'h00);
        check("t5_clear_idx", word_idx, 1);
        check("t5_clear_frame", frame_start, 0);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h00);
        for (int k = 0; k < WC; k++) begin
            for (int i = 0; i < WW; i++) begin
                step(1'b1, 1'b0, 1'b0, 1'b0);
            end
            cur = exp_q.pop_front();
            check("t5_ring", dout_word, cur);
        end

        // 6: asynchronous reset mid-word
        for (int i = 0; i < WW; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
        end
        check("t6_pre_dout", dout_word, 8'hFF);
        w = 8'h3C;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, 1'b0, w[i]);
        end
        check("t6_pre_bitcnt", bit_cnt, 5);
        #3;
        reset = 1'b1;
        #1;
        check("t6_async_dout", dout_word, 8'h00);
        check("t6_async_bitcnt", bit_cnt, 0);
        check("t6_async_idx", word_idx, 0);
        check("t6_async_frame", frame_start, 0);
        check("t6_async_sout", serial_out, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < WW - 1; i++) begin
            step(1'b1, 1'b1, 1'b0, w[i]);
        end
        check("t6_bitcnt7", bit_cnt, 7);
        check("t6_dout_pre", dout_word, 8'h00);
        check("t6_idx_pre", word_idx, 0);
        step(1'b1, 1'b1, 1'b0, w[7]);
        check("t6_dout", dout_word, 8'h3C);
        check("t6_idx", word_idx, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
